fifo_burst_drain: RTL
=====================

// Module: fifo_burst_drain
// PURPOSE
//   Downstream consumer of the 32-bit sync FIFO. Waits until a full burst is queued (or a
//   flush is requested), then pops words using the FIFO's registered 1-cycle read latency.
//   Presents the words on a valid/ready stream and marks the final word of each burst.
//   Sits between the FIFO and the packet/DMA egress logic.
// PARAMETERS
//   DATA_W     32   word width; must equal FIFO data width
//   BURST_LEN  16   words per burst (2..1023)
//   CNT_W      11   width of the FIFO occupancy input fifo_cnt
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   fifo_empty   in   1       FIFO empty flag
//   fifo_cnt     in   CNT_W   FIFO occupancy
//   fifo_dout    in   DATA_W  FIFO read data; valid the cycle after fifo_rd
//   fifo_rd      out  1       FIFO pop strobe
//   flush        in   1       level: drain a partial burst (1..BURST_LEN-1 words)
//   m_valid      out  1       output word valid
//   m_ready      in   1       downstream accept
//   m_data       out  DATA_W  output word
//   m_last       out  1       final word of the current burst
//   burst_done   out  1       1-cycle pulse after the m_last word is accepted
//   burst_cnt    out  16      completed bursts; wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async assert): all outputs 0; FSM=IDLE; skid buffer empty; rd_inflight=0.
//   FSM states:
//   - IDLE: go to ARM next cycle.
//   - ARM: when fifo_cnt>=BURST_LEN, load words_left=BURST_LEN and go to READ.
//     Else, if flush && !fifo_empty, load words_left=fifo_cnt and go to READ.
//     A full burst takes priority over flush.
//   - READ: issue pops. Go to DRAIN the cycle the last pop issues (words_left hits 0).
//   - DRAIN: wait until the m_last word is accepted, then pulse burst_done,
//     increment burst_cnt and return to ARM.
//   Pop rule (combinational):
//     fifo_rd = READ && words_left!=0 && !fifo_empty && (occ + rd_inflight - pop) < 2
//     occ = skid occupancy (0..2); pop = m_valid && m_ready.
//   rd_inflight <= fifo_rd. fifo_dout is written into the skid buffer the cycle after
//   fifo_rd. The buffer never overflows and never drops a word.
//   Throughput is one word per cycle with m_ready held high. First m_valid rises
//   2 cycles after the ARM->READ transition.
//   Stream rules:
//   - m_data/m_last stay stable while m_valid && !m_ready.
//   - m_valid never drops without a handshake.
//   m_last: tagged on the word whose pop decremented words_left to 0.
//   Flush: sampled only in ARM. Deasserting it mid-burst does not shorten the burst.
//   fifo_empty asserted in READ: stall popping and stay in READ. No timeout.
//   Accept and pop in the same cycle: occupancy unchanged. Data order is strictly FIFO.
//   Reset mid-burst: words already popped are discarded. The FIFO is reset by the same rst.
// CONFIGURATION
//   Macro FIFO_BURST_DRAIN_PARITY_EN.
//   - Defined: adds output m_par (1 bit) = ^m_data, registered alongside m_data in the
//     skid buffer. Adds input fifo_par; a mismatch with ^fifo_dout on a skid write sets
//     sticky output par_err. par_err clears only on rst.
//   - Undefined: no m_par, fifo_par or par_err ports, and no parity logic.
// STRUCTURE
//   Package fifo_burst_drain_pkg holds:
//   - typedef enum {IDLE,ARM,READ,DRAIN} drain_state_t
//   - localparam SKID_DEPTH=2
//   - localparam BURST_CNT_W=16
//   Sub-module drain_skid_buf: 2-entry buffer, {data,last[,par]} wide, with
//   wr/rd/occ ports. Owns the stream handshake. The FSM, counters and pop rule stay in
//   the top module.
// TESTING
//   1. fifo_cnt=16 preloaded 0..15, m_ready=1:
//      16 consecutive pops; m_data 0..15 on consecutive cycles; m_last on 15;
//      burst_done pulses once; burst_cnt=1.
//   2. Same preload, m_ready toggling 1,0,1,0:
//      no loss or duplication; m_data held during each stall; fifo_rd never pops with
//      occ+rd_inflight==2 and no pop.
//   3. fifo_cnt=5, flush=1:
//      5 words out; m_last on the 5th; FSM back in ARM; burst_cnt increments.
//   4. fifo_empty forced high for 3 cycles mid-burst:
//      fifo_rd low for those 3 cycles; burst resumes and completes with 16 words.
//   5. rst asserted asynchronously mid-burst (between edges):
//      m_valid, fifo_rd and burst_cnt go to 0 immediately; a fresh burst after release
//      is correct.
//   6. With FIFO_BURST_DRAIN_PARITY_EN, one word with bad fifo_par:
//      par_err rises the next cycle and stays high until rst.

Source files
------------

// File: rtl/fifo_burst_drain_pkg.sv
// ----------------------------------------------------------------------------
// fifo_burst_drain_pkg
// Shared types and constants for the FIFO burst drain block.
//   drain_state_t : drain controller states
//   SKID_DEPTH    : entries in the output skid buffer
//   BURST_CNT_W   : width of the completed-burst counter
// ----------------------------------------------------------------------------
package fifo_burst_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } drain_state_t;

   localparam int SKID_DEPTH  = 2;
   localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/drain_skid_buf.sv
// ----------------------------------------------------------------------------
// drain_skid_buf
// Two-entry buffer between the FIFO read port and the output stream. Owns the
// valid/ready handshake: the head entry is presented until it is accepted.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_i, wr_data_i   write strobe and word (caller guarantees no overflow)
//   rd_ready_i        downstream accept
//   rd_valid_o        head entry valid
//   rd_data_o         head entry
//   pop_o             handshake this cycle (rd_valid_o && rd_ready_i)
//   occ_o             current occupancy, 0..2
// ----------------------------------------------------------------------------
module drain_skid_buf
   import fifo_burst_drain_pkg::*;
#(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_ready_i,
   output logic         rd_valid_o,
   output logic [W-1:0] rd_data_o,
   output logic         pop_o,
   output logic [1:0]   occ_o
);

   logic [W-1:0] mem_q [SKID_DEPTH];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   occ_q;

   assign rd_valid_o = (occ_q != 2'd0);
   assign pop_o      = rd_valid_o && rd_ready_i;
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign occ_o      = occ_q;

   // Entries reset to zero so m_data reads 0 straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (wr_i) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop_o) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         // Simultaneous write and pop leaves occupancy unchanged.
         case ({wr_i, pop_o})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: rtl/fifo_burst_drain.sv
// ----------------------------------------------------------------------------
// fifo_burst_drain
// Drains a synchronous FIFO in bursts of BURST_LEN words (or a shorter burst
// when flush is held while armed) and presents the words on a valid/ready
// stream, tagging the final word of each burst with m_last.
// Optional feature macro: FIFO_BURST_DRAIN_PARITY_EN adds fifo_par, m_par and
// a sticky par_err flag.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   fifo_empty, fifo_cnt      FIFO status
//   fifo_dout                 FIFO read data, valid the cycle after fifo_rd
//   fifo_rd                   FIFO pop strobe
//   flush                     drain a partial burst (sampled while armed)
//   m_valid/m_ready/m_data    output stream
//   m_last                    final word of the burst
//   burst_done                one-cycle pulse after the m_last word is taken
//   burst_cnt                 completed bursts, wrapping
//   fifo_par, m_par, par_err  parity in/out and sticky error (macro only)
// ----------------------------------------------------------------------------
module fifo_burst_drain
   import fifo_burst_drain_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16,
   parameter int CNT_W     = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   input  logic [CNT_W-1:0]       fifo_cnt,
   input  logic [DATA_W-1:0]      fifo_dout,
   output logic                   fifo_rd,
   input  logic                   flush,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_last,
`ifdef FIFO_BURST_DRAIN_PARITY_EN
   input  logic                   fifo_par,
   output logic                   m_par,
   output logic                   par_err,
`endif
   output logic                   burst_done,
   output logic [BURST_CNT_W-1:0] burst_cnt
);

   localparam int WL_W = $clog2(BURST_LEN + 1);
`ifdef FIFO_BURST_DRAIN_PARITY_EN
   localparam int SKID_W = DATA_W + 2;
`else
   localparam int SKID_W = DATA_W + 1;
`endif

   drain_state_t           state_q, state_d;
   logic [WL_W-1:0]        wl_q, wl_d;
   logic                   rd_inflight_q;
   logic                   last_inflight_q;
   logic                   burst_done_q;
   logic [BURST_CNT_W-1:0] burst_cnt_q;

   logic                   rd_en;
   logic                   pop;
   logic [1:0]             occ;
   logic [SKID_W-1:0]      skid_wr_data;
   logic [SKID_W-1:0]      skid_rd_data;
   logic                   full_ready;
   logic                   flush_ready;
   logic                   burst_end;

   assign full_ready  = (fifo_cnt >= CNT_W'(BURST_LEN));
   // A zero count cannot start a burst even if the empty flag disagrees.
   assign flush_ready = flush && !fifo_empty && (fifo_cnt != '0);
   assign burst_end   = (state_q == DRAIN) && pop && m_last;

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = ARM;
         ARM:   if (full_ready || flush_ready) state_d = READ;
         READ:  if (rd_en && (wl_q == WL_W'(1))) state_d = DRAIN;
         DRAIN: if (burst_end) state_d = ARM;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Pop only when the word (plus any word still in flight) is guaranteed a
   // skid slot, counting the slot freed by a handshake this cycle.
   always_comb begin
      rd_en = (state_q == READ) && (wl_q != '0) && !fifo_empty &&
              (({1'b0, occ} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, pop}));
   end

   assign fifo_rd = rd_en;

   // Words-left counter: a full burst wins over flush.
   always_comb begin
      wl_d = wl_q;
      if (state_q == ARM) begin
         if (full_ready) begin
            wl_d = WL_W'(BURST_LEN);
         end else if (flush_ready) begin
            wl_d = WL_W'(fifo_cnt);
         end
      end else if (rd_en) begin
         wl_d = wl_q - WL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wl_q            <= '0;
         rd_inflight_q   <= 1'b0;
         last_inflight_q <= 1'b0;
         burst_done_q    <= 1'b0;
         burst_cnt_q     <= '0;
      end else begin
         wl_q            <= wl_d;
         rd_inflight_q   <= rd_en;
         // The pop that empties words_left carries the last tag to the buffer.
         last_inflight_q <= rd_en && (wl_q == WL_W'(1));
         burst_done_q    <= burst_end;
         if (burst_end) begin
            burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
         end
      end
   end

`ifdef FIFO_BURST_DRAIN_PARITY_EN
   logic par_err_q;

   assign skid_wr_data = {fifo_dout, last_inflight_q, ^fifo_dout};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_err_q <= 1'b0;
      end else if (rd_inflight_q && (fifo_par != ^fifo_dout)) begin
         par_err_q <= 1'b1;
      end
   end

   assign par_err = par_err_q;
   assign m_par   = skid_rd_data[0];
`else
   assign skid_wr_data = {fifo_dout, last_inflight_q};
`endif

   drain_skid_buf #(
      .W (SKID_W)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (rd_inflight_q),
      .wr_data_i  (skid_wr_data),
      .rd_ready_i (m_ready),
      .rd_valid_o (m_valid),
      .rd_data_o  (skid_rd_data),
      .pop_o      (pop),
      .occ_o      (occ)
   );

   assign m_data     = skid_rd_data[SKID_W-1 -: DATA_W];
   assign m_last     = skid_rd_data[SKID_W-DATA_W-1];
   assign burst_done = burst_done_q;
   assign burst_cnt  = burst_cnt_q;

endmodule
